// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: freezes on multi-cycle data-memory
// accesses, inserts load-use bubbles, flushes IF/ID on taken branches/jumps, counts events.
module pipeline_stall_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             IsBranch_i,
    input  logic             BranchEq_i,
    input  logic             IsJump_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_Rt_i,
    input  logic [4:0]       IFID_Rs_i,
    input  logic [4:0]       IFID_Rt_i,
    input  logic             MemAccess_i,
    input  logic             mem_ack_i,
    output logic             mem_req_o,
    output logic             PCWrite_o,
    output logic             IFIDWrite_o,
    output logic             IFIDFlush_o,
    output logic             IDEXBubble_o,
    output logic             Stall_o,
    output logic             error_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int unsigned WAIT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_MEM_WAIT,
        S_MEM_DONE,
        S_ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               mem_req_q, mem_req_d;
    logic               error_q, error_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic stall_c;
    logic load_use_c;
    logic flush_c;
    logic count_en_c;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= '0;
            mem_req_q   <= 1'b0;
            error_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_req_q   <= mem_req_d;
            error_q     <= error_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next state, hazard resolution and counter updates
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        stall_c     = 1'b0;
        count_en_c  = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                stall_c    = 1'b1;
                count_en_c = 1'b0;
                if (start_i) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (MemAccess_i) begin
                    stall_c    = 1'b1;
                    state_d    = S_MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            S_MEM_WAIT: begin
                stall_c = 1'b1;
                if (mem_ack_i) begin
                    state_d = S_MEM_DONE;
                end else if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    state_d = S_ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            S_MEM_DONE: begin
                state_d = S_RUN;
            end
            S_ERROR: begin
                stall_c    = 1'b1;
                count_en_c = 1'b0;
            end
            default: begin
                stall_c = 1'b1;
                state_d = S_IDLE;
            end
        endcase

        load_use_c = !stall_c && IDEX_MemRead_i && (IDEX_Rt_i != 5'd0) &&
                     ((IDEX_Rt_i == IFID_Rs_i) || (IDEX_Rt_i == IFID_Rt_i));
        flush_c    = !stall_c && !load_use_c &&
                     ((IsBranch_i && BranchEq_i) || IsJump_i);

        mem_req_d = (state_d == S_MEM_WAIT);
        error_d   = (state_d == S_ERROR);

        if (count_en_c && (stall_c || load_use_c) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_c && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    assign Stall_o      = stall_c;
    assign PCWrite_o    = !stall_c && !load_use_c;
    assign IFIDWrite_o  = !stall_c && !load_use_c;
    assign IDEXBubble_o = load_use_c;
    assign IFIDFlush_o  = flush_c;
    assign mem_req_o    = mem_req_q;
    assign error_o      = error_q;
    assign stall_cnt_o  = stall_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It freezes the whole pipeline while the MEM stage waits on a multi-cycle data-memory handshake. It inserts load-use bubbles, flushes IF/ID on taken branches and jumps (resolved in ID), and keeps saturating performance counters. It sits beside the ID-stage decoder and drives the PC, IF/ID and ID/EX register enables.

Parameters:
MEM_TIMEOUT, 16, maximum MEM_WAIT cycles without ack before entering ERROR (2..255)
CNT_W, 16, width of the performance counters

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-low
start_i  in  1  begin execution (one-cycle pulse is sufficient)
IsBranch_i  in  1  ID-stage instruction is BEQ
BranchEq_i  in  1  ID-stage register comparison equal
IsJump_i  in  1  ID-stage instruction is J
IDEX_MemRead_i  in  1  EX-stage instruction is LW
IDEX_Rt_i  in  5  EX-stage destination register
IFID_Rs_i  in  5  ID-stage rs
IFID_Rt_i  in  5  ID-stage rt
MemAccess_i  in  1  MEM-stage instruction is LW or SW
mem_ack_i  in  1  data memory completes access
mem_req_o  out  1  data memory request (registered)
PCWrite_o  out  1  PC update enable
IFIDWrite_o  out  1  IF/ID register enable
IFIDFlush_o  out  1  zero the IF/ID register
IDEXBubble_o  out  1  force ID/EX control fields to zero
Stall_o  out  1  freeze all pipeline registers
error_o  out  1  sticky memory-timeout error
stall_cnt_o  out  CNT_W  cycles with Stall_o or IDEXBubble_o high, saturating
flush_cnt_o  out  CNT_W  cycles with IFIDFlush_o high, saturating

Behaviour:
- States: IDLE, RUN, MEM_WAIT, MEM_DONE, ERROR. Reset (rst_i=0, asynchronous) forces IDLE, mem_req_o=0, error_o=0, wait counter=0, both perf counters=0.
- IDLE: Stall_o=1, PCWrite_o=0, IFIDWrite_o=0. Move to RUN the cycle after start_i=1. start_i is ignored in all other states.
- RUN with MemAccess_i=1: Stall_o=1 combinationally in that cycle. Next state MEM_WAIT, with mem_req_o=1 and the wait counter cleared.
- MEM_WAIT: Stall_o=1, mem_req_o=1.
  - mem_ack_i=1: go to MEM_DONE; mem_req_o=0 next cycle.
  - No ack: the counter increments. At counter==MEM_TIMEOUT-1 with no ack, go to ERROR.
  - Ack in the timeout cycle: ack wins.
- MEM_DONE: exactly one cycle. Stall_o=0 and MemAccess_i is ignored so the completed instruction leaves MEM. Return to RUN. Back-to-back LW/SW therefore costs ≥3 cycles each: RUN detect, ≥1 wait, done.
- ERROR: Stall_o=1, mem_req_o=0, error_o=1. The state is held until reset.
- Enables: PCWrite_o=IFIDWrite_o=~Stall_o, except during a load-use hazard.
- Load-use hazard (only when Stall_o=0):
  - Condition: IDEX_MemRead_i && IDEX_Rt_i!=0 && (IDEX_Rt_i==IFID_Rs_i || IDEX_Rt_i==IFID_Rt_i).
  - Response: PCWrite_o=0, IFIDWrite_o=0, IDEXBubble_o=1.
- Flush (only when Stall_o=0 and no load-use): IFIDFlush_o = (IsBranch_i && BranchEq_i) || IsJump_i. The branch/jump is re-evaluated the cycle after a load-use bubble.
- Priority: Stall_o > load-use > flush. IDEXBubble_o and IFIDFlush_o are never 1 while Stall_o=1.
- All outputs except mem_req_o, error_o and the counters are combinational from state and inputs.
- Counters increment on the clock edge when their condition holds and saturate at all-ones. Stall counting excludes IDLE and ERROR.

Test Plan:
- Reset, start_i pulse -> Stall_o=1 until the cycle after start_i; then Stall_o=0, PCWrite_o=1; both counters 0.
- MemAccess_i=1 in RUN, mem_ack_i after 3 MEM_WAIT cycles -> Stall_o=1 for 4 cycles, mem_req_o=1 for 3, then one MEM_DONE cycle with Stall_o=0; stall_cnt_o=4.
- IDEX_MemRead_i=1, IDEX_Rt_i=5, IFID_Rs_i=5, IsJump_i=1 -> IDEXBubble_o=1, PCWrite_o=0, IFIDFlush_o=0. Same with IDEX_Rt_i=0 -> no bubble, IFIDFlush_o=1; flush_cnt_o +1.
- MEM_TIMEOUT=4, no ack -> ERROR after 4 MEM_WAIT cycles, error_o=1, Stall_o=1 held. Ack in the 4th wait cycle -> MEM_DONE, no error.
- rst_i=0 mid-MEM_WAIT -> mem_req_o=0 immediately (asynchronous), state IDLE, counters 0.
- Force the stall condition 2^CNT_W+2 cycles (CNT_W=4 build) -> stall_cnt_o saturates at 15.
